ex_hazard_scheduler: RTL and testbench
======================================

Name: ex_hazard_scheduler

Overview:
- Pipeline control block that sequences the ID/EX stage and the EX-stage AI unit.
- Detects load-use hazards and taken-branch flushes, and generates forwarding selects for both EX operands.
- Holds the pipeline for multi-cycle AI operations, sized by opcode latency.
- Sits beside the ID/EX and EX/MEM pipeline registers and drives their hold, bubble and flush controls. It also keeps a saturating stall-cycle statistics counter.

Parameters:
- AI_LAT_SHORT, 2: EX cycles for ai_opcode 0-3. A value of 0 is treated as 1.
- AI_LAT_LONG, 6: EX cycles for ai_opcode 4-7. A value of 0 is treated as 1.
- CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rs1_id  in  5  ID-stage source register 1
- rs2_id  in  5  ID-stage source register 2
- uses_rs1_id  in  1  ID instruction reads rs1
- uses_rs2_id  in  1  ID instruction reads rs2
- rs1_ex  in  5  ID/EX source register 1
- rs2_ex  in  5  ID/EX source register 2
- rd_ex  in  5  ID/EX destination register
- memread_ex  in  1  EX instruction is a load
- is_ai_ex  in  1  EX instruction is an AI op
- ai_opcode_ex  in  3  EX AI opcode
- branch_taken_ex  in  1  branch resolved taken in EX
- rd_mem  in  5  EX/MEM destination register
- regwrite_mem  in  1  EX/MEM register write enable
- rd_wb  in  5  MEM/WB destination register
- regwrite_wb  in  1  MEM/WB register write enable
- stat_clr  in  1  synchronous clear of stall_count
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID
- idex_hold  out  1  hold ID/EX contents
- idex_bubble  out  1  load a NOP (all controls 0) into ID/EX
- exmem_bubble  out  1  load a NOP into EX/MEM
- fwd_a  out  2  operand A select: 00 register file, 01 WB, 10 MEM
- fwd_b  out  2  operand B select, same encoding
- ai_start  out  1  one-cycle pulse when an AI op begins
- ai_busy  out  1  AI op in progress
- ai_done  out  1  AI result valid this cycle
- stall_count  out  CNT_W  cycles with pc_stall=1

Behaviour:
- **AI latency selection.** LAT = AI_LAT_SHORT if ai_opcode_ex[2]==0, else AI_LAT_LONG.
- **AI FSM, states IDLE and RUN.** Down-counter cnt is 3 bits wider than needed for the larger LAT.
- **IDLE, is_ai_ex=1:**
  - ai_start=1.
  - If LAT==1: ai_done=1, no hold, stay in IDLE.
  - Otherwise: hold asserted, cnt<=LAT-1, go to RUN.
- **RUN:**
  - ai_busy=1 and cnt decrements each cycle.
  - While cnt>1: hold asserted.
  - When cnt==1: ai_done=1, hold deasserted, go to IDLE at the clock edge.
  - Net effect: an AI instruction occupies EX for exactly LAT cycles. ai_start is high in only the first of them.
- **ai_busy.** High in every cycle in which hold is asserted.
- **Hold actions.** pc_stall=ifid_stall=idex_hold=exmem_bubble=1. ifid_flush=idex_bubble=0.
- **Branch flush.** Applies when hold=0 and branch_taken_ex=1: ifid_flush=1 and idex_bubble=1. pc_stall and ifid_stall stay 0.
- **Load-use stall.** Applies when hold=0, branch_taken_ex=0, memread_ex=1, rd_ex!=0, and (uses_rs1_id and rd_ex==rs1_id) or (uses_rs2_id and rd_ex==rs2_id).
  - pc_stall=ifid_stall=idex_bubble=1 for one cycle.
  - The bubble removes the condition in the next cycle.
- **Priority.** AI hold > branch flush > load-use. Only one action applies per cycle.
- **Forwarding, fwd_a:**
  - 10 if regwrite_mem and rd_mem!=0 and rd_mem==rs1_ex.
  - Else 01 if regwrite_wb and rd_wb!=0 and rd_wb==rs1_ex.
  - Else 00.
  - MEM wins over WB. Forwarding is active even during hold.
- **Forwarding, fwd_b.** Same rules, using rs2_ex.
- **Output timing.** All control outputs are combinational from the inputs and state, with no added latency.
- **stall_count:**
  - Increments on each clock edge where pc_stall=1.
  - Saturates at all-ones.
  - stat_clr=1 zeroes it, with priority over increment.
- **Reset.**
  - Asynchronous reset forces state IDLE, cnt=0, stall_count=0.
  - While reset is high, every combinational output is forced to 0.
  - Reset during RUN abandons the AI op: no ai_done is produced.
- **Register x0.** Never creates a hazard or a forward.

Test Plan:
- **Load-use.** ID/EX load with rd_ex=5 and memread_ex=1; ID rs1_id=5, uses_rs1_id=1 -> one cycle of pc_stall=ifid_stall=idex_bubble=1, then all 0. Repeat with rd_ex=0 -> no stall.
- **Forwarding priority.** rs1_ex=7, rd_mem=7, rd_wb=7, both regwrite=1 -> fwd_a=10. Drop regwrite_mem -> 01. rs2_ex=0 with rd_mem=0 -> fwd_b=00.
- **Short AI op.** ai_opcode_ex=1 with AI_LAT_SHORT=2 -> ai_start and hold for 1 cycle, ai_done in cycle 2, exmem_bubble high for 1 cycle. stall_count goes 0 -> 1.
- **Long AI op with competing events.** ai_opcode_ex=5 with AI_LAT_LONG=6; assert branch_taken_ex and a load-use condition during the op -> hold for 5 cycles with ifid_flush=0 throughout, ai_done on cycle 6, stall_count=5.
- **Reset during AI op.** Assert reset during RUN at cnt=3 -> all outputs 0 immediately and stall_count=0. After release, state is IDLE and no ai_done appears.
- **Counter saturation and clear.** With CNT_W=4, hold a stall source for 20 cycles -> stall_count stops at 15. Pulse stat_clr together with a stall -> stall_count=0.

Source files
------------

// File: rtl/ex_hazard_scheduler.sv
// ID/EX hazard scheduler: AI-unit multi-cycle hold, branch flush, load-use stall,
// EX operand forwarding selects and a saturating stall-cycle counter.
module ex_hazard_scheduler #(
    parameter int AI_LAT_SHORT = 2,
    parameter int AI_LAT_LONG  = 6,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic             is_ai_ex,
    input  logic [2:0]       ai_opcode_ex,
    input  logic             branch_taken_ex,
    input  logic [4:0]       rd_mem,
    input  logic             regwrite_mem,
    input  logic [4:0]       rd_wb,
    input  logic             regwrite_wb,
    input  logic             stat_clr,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ai_start,
    output logic             ai_busy,
    output logic             ai_done,
    output logic [CNT_W-1:0] stall_count
);

    // A latency of 0 behaves like a single-cycle op.
    localparam int LAT_S   = (AI_LAT_SHORT < 1) ? 1 : AI_LAT_SHORT;
    localparam int LAT_L   = (AI_LAT_LONG  < 1) ? 1 : AI_LAT_LONG;
    localparam int LAT_MAX = (LAT_S > LAT_L) ? LAT_S : LAT_L;
    localparam int CW      = $clog2(LAT_MAX + 1) + 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ai_state_t;

    ai_state_t     state;
    ai_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] lat;
    logic          hold;
    logic          load_use;

    assign lat = ai_opcode_ex[2] ? CW'(LAT_L) : CW'(LAT_S);

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       rwm,
        input logic [4:0] rdw,
        input logic       rww
    );
        if (rwm && (rdm != 5'd0) && (rdm == rs))
            return 2'b10;
        else if (rww && (rdw != 5'd0) && (rdw == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (is_ai_ex && (lat != CW'(1))) begin
                    state_nx = RUN;
                    cnt_nx   = lat - CW'(1);
                end
            end
            RUN: begin
                cnt_nx = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign load_use = memread_ex && (rd_ex != 5'd0) &&
                      ((uses_rs1_id && (rd_ex == rs1_id)) ||
                       (uses_rs2_id && (rd_ex == rs2_id)));

    // Everything is gated by reset so an abandoned AI op never reports done.
    always_comb begin
        hold         = 1'b0;
        ai_start     = 1'b0;
        ai_busy      = 1'b0;
        ai_done      = 1'b0;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (is_ai_ex) begin
                        ai_start = 1'b1;
                        if (lat == CW'(1)) ai_done = 1'b1;
                        else               hold    = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt > CW'(1)) hold    = 1'b1;
                    else              ai_done = 1'b1;
                end
                default: ;
            endcase
            ai_busy = hold || (state == RUN);

            if (hold) begin
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_hold    = 1'b1;
                exmem_bubble = 1'b1;
            end else if (branch_taken_ex) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end

            fwd_a = fwd_sel(rs1_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb);
            fwd_b = fwd_sel(rs2_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stat_clr)
            stall_count <= '0;
        else if (pc_stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Directed bench for ex_hazard_scheduler: the driver pushes the expected output
// vector for each cycle, the monitor pops and compares it on the falling edge.
module tb_ex_hazard_scheduler;

    localparam int CW = 4;
    localparam int EW = 17;

    // Control group order: pc_stall, ifid_stall, ifid_flush, idex_hold, idex_bubble, exmem_bubble
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_BR   = 6'b001010;
    localparam logic [5:0] C_HOLD = 6'b110101;

    logic          clk;
    logic          reset;
    logic [4:0]    rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic          uses_rs1_id, uses_rs2_id, memread_ex, is_ai_ex, branch_taken_ex;
    logic [2:0]    ai_opcode_ex;
    logic          regwrite_mem, regwrite_wb, stat_clr;
    logic          pc_stall, ifid_stall, ifid_flush, idex_hold, idex_bubble, exmem_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic          ai_start, ai_busy, ai_done;
    logic [CW-1:0] stall_count;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks;
    int            n_fail;

    ex_hazard_scheduler #(
        .AI_LAT_SHORT(2),
        .AI_LAT_LONG (6),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .uses_rs1_id    (uses_rs1_id),
        .uses_rs2_id    (uses_rs2_id),
        .rs1_ex         (rs1_ex),
        .rs2_ex         (rs2_ex),
        .rd_ex          (rd_ex),
        .memread_ex     (memread_ex),
        .is_ai_ex       (is_ai_ex),
        .ai_opcode_ex   (ai_opcode_ex),
        .branch_taken_ex(branch_taken_ex),
        .rd_mem         (rd_mem),
        .regwrite_mem   (regwrite_mem),
        .rd_wb          (rd_wb),
        .regwrite_wb    (regwrite_wb),
        .stat_clr       (stat_clr),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_hold      (idex_hold),
        .idex_bubble    (idex_bubble),
        .exmem_bubble   (exmem_bubble),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .ai_start       (ai_start),
        .ai_busy        (ai_busy),
        .ai_done        (ai_done),
        .stall_count    (stall_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [EW-1:0] ex(input logic [5:0] c, input logic [1:0] fa,
                                         input logic [1:0] fb, input logic [2:0] ai,
                                         input logic [CW-1:0] sc);
        return {c, fa, fb, ai, sc};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [EW-1:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic clear_in();
        rs1_id = 0; rs2_id = 0; uses_rs1_id = 0; uses_rs2_id = 0;
        rs1_ex = 0; rs2_ex = 0; rd_ex = 0; memread_ex = 0;
        is_ai_ex = 0; ai_opcode_ex = 0; branch_taken_ex = 0;
        rd_mem = 0; regwrite_mem = 0; rd_wb = 0; regwrite_wb = 0; stat_clr = 0;
    endtask

    task automatic set_lu();
        memread_ex = 1; rd_ex = 5; rs1_id = 5; uses_rs1_id = 1;
    endtask

    // Scoreboard monitor
    initial begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {pc_stall, ifid_stall, ifid_flush, idex_hold, idex_bubble, exmem_bubble,
                       fwd_a, fwd_b, ai_start, ai_busy, ai_done, stall_count};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", nm, act, e);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_in();

        tick(); set_lu(); branch_taken_ex = 1; rs1_ex = 2; rd_mem = 2; regwrite_mem = 1;
        push("reset_state", ex(C_NONE, 2'b00, 2'b00, 3'b000, 0));
        tick(); reset = 0; clear_in();
        push("idle_after_reset", ex(C_NONE, 2'b00, 2'b00, 3'b000, 0));

        tick(); set_lu();
        push("load_use_rs1", ex(C_LU, 2'b00, 2'b00, 3'b000, 0));
        tick(); clear_in();
        push("after_bubble", ex(C_NONE, 2'b00, 2'b00, 3'b000, 1));
        tick(); memread_ex = 1; rd_ex = 0; rs1_id = 0; uses_rs1_id = 1;
        push("load_x0", ex(C_NONE, 2'b00, 2'b00, 3'b000, 1));
        tick(); clear_in(); memread_ex = 1; rd_ex = 9; rs2_id = 9; uses_rs2_id = 1; rs1_id = 3; uses_rs1_id = 1;
        push("load_use_rs2", ex(C_LU, 2'b00, 2'b00, 3'b000, 1));
        tick(); uses_rs2_id = 0;
        push("rs2_not_used", ex(C_NONE, 2'b00, 2'b00, 3'b000, 2));

        tick(); clear_in(); rs1_ex = 7; rs2_ex = 7; rd_mem = 7; rd_wb = 7; regwrite_mem = 1; regwrite_wb = 1;
        push("fwd_mem_prio", ex(C_NONE, 2'b10, 2'b10, 3'b000, 2));
        tick(); regwrite_mem = 0;
        push("fwd_wb", ex(C_NONE, 2'b01, 2'b01, 3'b000, 2));
        tick(); regwrite_mem = 1; rd_mem = 0; rs2_ex = 0;
        push("fwd_x0", ex(C_NONE, 2'b01, 2'b00, 3'b000, 2));
        tick(); clear_in(); rs1_ex = 3; rs2_ex = 3; rd_mem = 3; rd_wb = 3;
        push("fwd_no_write", ex(C_NONE, 2'b00, 2'b00, 3'b000, 2));

        tick(); clear_in(); set_lu(); branch_taken_ex = 1; stat_clr = 1;
        push("branch_over_lu", ex(C_BR, 2'b00, 2'b00, 3'b000, 2));

        tick(); clear_in(); is_ai_ex = 1; ai_opcode_ex = 1; rs1_ex = 4; rd_mem = 4; regwrite_mem = 1;
        push("ai_short_start", ex(C_HOLD, 2'b10, 2'b00, 3'b110, 0));
        tick();
        push("ai_short_done", ex(C_NONE, 2'b10, 2'b00, 3'b011, 1));
        tick(); clear_in(); stat_clr = 1;
        push("ai_short_idle", ex(C_NONE, 2'b00, 2'b00, 3'b000, 1));

        tick(); stat_clr = 0; is_ai_ex = 1; ai_opcode_ex = 5; branch_taken_ex = 1; set_lu();
        push("ai_long_start", ex(C_HOLD, 2'b00, 2'b00, 3'b110, 0));
        for (int i = 1; i <= 4; i++) begin
            tick();
            push("ai_long_hold", ex(C_HOLD, 2'b00, 2'b00, 3'b010, CW'(i)));
        end
        tick(); clear_in(); is_ai_ex = 1; ai_opcode_ex = 5;
        push("ai_long_done", ex(C_NONE, 2'b00, 2'b00, 3'b011, 5));
        tick(); clear_in();
        push("ai_long_idle", ex(C_NONE, 2'b00, 2'b00, 3'b000, 5));

        tick(); is_ai_ex = 1; ai_opcode_ex = 6;
        push("ai_rst_start", ex(C_HOLD, 2'b00, 2'b00, 3'b110, 5));
        tick();
        push("ai_rst_run5", ex(C_HOLD, 2'b00, 2'b00, 3'b010, 6));
        tick();
        push("ai_rst_run4", ex(C_HOLD, 2'b00, 2'b00, 3'b010, 7));
        tick(); reset = 1; rs1_ex = 2; rd_mem = 2; regwrite_mem = 1; branch_taken_ex = 1;
        push("reset_in_run", ex(C_NONE, 2'b00, 2'b00, 3'b000, 0));
        tick(); reset = 0; clear_in();
        push("no_done_after_reset", ex(C_NONE, 2'b00, 2'b00, 3'b000, 0));
        tick(); is_ai_ex = 1; ai_opcode_ex = 2;
        push("restart_from_idle", ex(C_HOLD, 2'b00, 2'b00, 3'b110, 0));
        tick();
        push("restart_done", ex(C_NONE, 2'b00, 2'b00, 3'b011, 1));

        tick(); clear_in(); set_lu();
        push("sat_stall", ex(C_LU, 2'b00, 2'b00, 3'b000, 1));
        for (int k = 1; k < 20; k++) begin
            tick();
            push("sat_stall", ex(C_LU, 2'b00, 2'b00, 3'b000, (k + 1 > 15) ? CW'(15) : CW'(k + 1)));
        end
        tick(); stat_clr = 1;
        push("clr_with_stall", ex(C_LU, 2'b00, 2'b00, 3'b000, 15));
        tick(); clear_in();
        push("after_clear", ex(C_NONE, 2'b00, 2'b00, 3'b000, 0));

        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
